prog_load_ctrl: RTL and testbench
=================================

PROG_LOAD_CTRL -- requirements
Module: prog_load_ctrl

Interface
REQ-001 SHALL have: clk  input  1  system clock; all state changes on posedge clk.
REQ-002 SHALL have: reset  input  1  asynchronous, active-high reset.
REQ-003 SHALL have: rx_valid  input  1  one-cycle strobe; rx_data holds a received byte.
REQ-004 SHALL have: rx_data  input  8  received byte (big-endian stream).
REQ-005 SHALL have: load_start  input  1  pulse; begin program download.
REQ-006 SHALL have: run  input  1  pulse; free-run CPU.
REQ-007 SHALL have: step  input  1  pulse; execute one CPU clock.
REQ-008 SHALL have: stop  input  1  pulse; pause free-running CPU.
REQ-009 SHALL have: cpu_halted  input  1  high while CPU control unit sits in HALT.
REQ-010 SHALL have: cpu_reset  output  1  held-reset to CPU control unit and PC.
REQ-011 SHALL have: cpu_ce  output  1  CPU clock enable.
REQ-012 SHALL have: mem_sel  output  1  1 = loader owns memory port, 0 = CPU.
REQ-013 SHALL have: ld_mw_en  output  1  loader memory write enable.
REQ-014 SHALL have: ld_addr  output  16  loader write address.
REQ-015 SHALL have: ld_wdata  output  16  loader write data.
REQ-016 SHALL have: state  output  4  present-state code for LEDs.

Function
REQ-017 States SHALL be IDLE, LEN_HI, LEN_LO, DAT_HI, DAT_LO, WRITE, READY, RUN, STEP, HALTED.
REQ-018 IDLE: load_start -> LEN_HI; run -> RUN; step -> STEP; else stay.
REQ-019 LEN_HI: on rx_valid capture len[15:8] -> LEN_LO; LEN_LO: on rx_valid capture len[7:0], clear ld_addr to 0.
REQ-020 LEN_LO SHALL go to READY if captured length is 0, else DAT_HI.
REQ-021 DAT_HI: on rx_valid capture ld_wdata[15:8] -> DAT_LO; DAT_LO: on rx_valid capture ld_wdata[7:0] -> WRITE.
REQ-022 WRITE SHALL last exactly one cycle with ld_mw_en=1 at current ld_addr, then increment ld_addr (16-bit wrap).
REQ-023 WRITE SHALL go to READY when the written word was word len-1, else DAT_HI.
REQ-024 In all states rx_valid SHALL be ignored except LEN_HI, LEN_LO, DAT_HI, DAT_LO.
REQ-025 load_start, run, step, stop SHALL be ignored during LEN_HI..WRITE.
REQ-026 cpu_reset=1 and mem_sel=1 in IDLE and LEN_HI..WRITE; cpu_reset=0 and mem_sel=0 in READY, RUN, STEP, HALTED.
REQ-027 READY: cpu_ce=0; run -> RUN; step -> STEP; load_start -> LEN_HI; run SHALL win over step if simultaneous.
REQ-028 RUN: cpu_ce=1; cpu_halted -> HALTED; stop -> READY; cpu_halted SHALL win over stop.
REQ-029 STEP: cpu_ce=1 for exactly one cycle, then HALTED if cpu_halted else READY.
REQ-030 HALTED: cpu_ce=0; load_start -> LEN_HI; run/step/stop ignored.
REQ-031 ld_mw_en SHALL be 0 in every state except WRITE.
REQ-032 All outputs SHALL be registered or decoded from registered state only (Moore).

Reset
REQ-033 reset SHALL force state IDLE, cpu_reset=1, cpu_ce=0, mem_sel=1, ld_mw_en=0, ld_addr=0, ld_wdata=0, len=0, at any time including mid-download.
REQ-034 Download in progress at reset SHALL be abandoned; no further write issued.

Structure
REQ-035 State codes (IDLE=0 .. HALTED=9) SHALL live in the shared cpu package with the control unit opcode constants.
REQ-036 Byte-to-word assembly SHALL be one sub-module, word_assembler (hi/lo capture, word_valid strobe).

Verification
REQ-037 Stream 00 02 12 34 AB CD after load_start -> writes 0x1234@0, 0xABCD@1, one ld_mw_en cycle each, then READY.
REQ-038 Stream 00 00 -> READY directly, zero ld_mw_en pulses, cpu_reset drops.
REQ-039 READY, run and step same cycle -> RUN, cpu_ce=1 continuously; cpu_halted=1 -> HALTED next cycle, cpu_ce=0.
REQ-040 READY, step pulse -> cpu_ce high exactly one cycle, return to READY.
REQ-041 reset asserted after byte 12 of REQ-037 stream -> IDLE, ld_addr=0, no write; fresh download succeeds.
REQ-042 run pulse and rx_valid during DAT_LO -> run ignored, write proceeds normally.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: control-unit opcodes and loader/run-control state codes.
package cpu_pkg;

  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] OP_LOAD  = 4'h1;
  localparam logic [3:0] OP_STORE = 4'h2;
  localparam logic [3:0] OP_ADD   = 4'h3;
  localparam logic [3:0] OP_SUB   = 4'h4;
  localparam logic [3:0] OP_JMP   = 4'h5;
  localparam logic [3:0] OP_JZ    = 4'h6;
  localparam logic [3:0] OP_HALT  = 4'hF;

  // Codes are visible on the LEDs, so their values are fixed.
  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_LEN_HI = 4'd1,
    ST_LEN_LO = 4'd2,
    ST_DAT_HI = 4'd3,
    ST_DAT_LO = 4'd4,
    ST_WRITE  = 4'd5,
    ST_READY  = 4'd6,
    ST_RUN    = 4'd7,
    ST_STEP   = 4'd8,
    ST_HALTED = 4'd9
  } ld_state_e;

  // States in which the CPU is held in reset and the loader owns memory.
  function automatic logic is_loader_state(input ld_state_e s);
    return (s == ST_IDLE)   || (s == ST_LEN_HI) || (s == ST_LEN_LO) ||
           (s == ST_DAT_HI) || (s == ST_DAT_LO) || (s == ST_WRITE);
  endfunction

endpackage

// File: rtl/prog_load_ctrl_word_assembler.sv
// Packs a big-endian byte pair into a 16-bit word; word_vld_o strobes for one
// cycle after the low byte is captured.
module word_assembler (
  input  logic        clk,
  input  logic        reset,
  input  logic        hi_vld_i,
  input  logic        lo_vld_i,
  input  logic [7:0]  byte_i,
  output logic [15:0] word_o,
  output logic        word_vld_o
);

  logic [15:0] word_q, word_d;
  logic        vld_q, vld_d;

  always_comb begin
    word_d = word_q;
    vld_d  = lo_vld_i;
    if (hi_vld_i) word_d[15:8] = byte_i;
    if (lo_vld_i) word_d[7:0]  = byte_i;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      word_q <= '0;
      vld_q  <= 1'b0;
    end else begin
      word_q <= word_d;
      vld_q  <= vld_d;
    end
  end

  assign word_o     = word_q;
  assign word_vld_o = vld_q;

endmodule

// File: rtl/prog_load_ctrl.sv
// Program download over a byte stream into CPU memory, then run/step/stop
// control of the CPU. Moore machine: every output comes from registered state.
module prog_load_ctrl
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  input  logic        load_start,
  input  logic        run,
  input  logic        step,
  input  logic        stop,
  input  logic        cpu_halted,
  output logic        cpu_reset,
  output logic        cpu_ce,
  output logic        mem_sel,
  output logic        ld_mw_en,
  output logic [15:0] ld_addr,
  output logic [15:0] ld_wdata,
  output logic [3:0]  state
);

  ld_state_e   state_q, state_d;
  logic [15:0] len_q, len_d;
  logic [15:0] addr_q, addr_d;
  logic        word_vld;

  word_assembler u_word_asm (
    .clk        (clk),
    .reset      (reset),
    .hi_vld_i   (rx_valid && (state_q == ST_DAT_HI)),
    .lo_vld_i   (rx_valid && (state_q == ST_DAT_LO)),
    .byte_i     (rx_data),
    .word_o     (ld_wdata),
    .word_vld_o (word_vld)
  );

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    addr_d  = addr_q;
    unique case (state_q)
      ST_IDLE: begin
        if (load_start)  state_d = ST_LEN_HI;
        else if (run)    state_d = ST_RUN;
        else if (step)   state_d = ST_STEP;
      end
      ST_LEN_HI: if (rx_valid) begin
        len_d[15:8] = rx_data;
        state_d     = ST_LEN_LO;
      end
      ST_LEN_LO: if (rx_valid) begin
        len_d[7:0] = rx_data;
        addr_d     = '0;
        // Decide on the freshly assembled length, not the stale register.
        state_d    = ({len_q[15:8], rx_data} == 16'd0) ? ST_READY : ST_DAT_HI;
      end
      ST_DAT_HI: if (rx_valid) state_d = ST_DAT_LO;
      ST_DAT_LO: if (rx_valid) state_d = ST_WRITE;
      ST_WRITE: begin
        addr_d  = addr_q + 16'd1;
        state_d = (addr_q == len_q - 16'd1) ? ST_READY : ST_DAT_HI;
      end
      ST_READY: begin
        if (run)             state_d = ST_RUN;
        else if (step)       state_d = ST_STEP;
        else if (load_start) state_d = ST_LEN_HI;
      end
      ST_RUN: begin
        if (cpu_halted)  state_d = ST_HALTED;
        else if (stop)   state_d = ST_READY;
      end
      ST_STEP:   state_d = cpu_halted ? ST_HALTED : ST_READY;
      ST_HALTED: if (load_start) state_d = ST_LEN_HI;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      len_q   <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      addr_q  <= addr_d;
    end
  end

  assign cpu_reset = is_loader_state(state_q);
  assign mem_sel   = is_loader_state(state_q);
  assign cpu_ce    = (state_q == ST_RUN) || (state_q == ST_STEP);
  assign ld_mw_en  = word_vld && (state_q == ST_WRITE);
  assign ld_addr   = addr_q;
  assign state     = state_q;

endmodule

// File: tb/tb_prog_load_ctrl.sv
// Directed bench for prog_load_ctrl: download, zero-length, run/step/halt, reset abort.
module tb_prog_load_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        load_start = 1'b0, run = 1'b0, step = 1'b0, stop = 1'b0;
  logic        cpu_halted = 1'b0;
  logic        cpu_reset, cpu_ce, mem_sel, ld_mw_en;
  logic [15:0] ld_addr, ld_wdata;
  logic [3:0]  state;

  int n_vec = 0;
  int n_err = 0;
  logic [15:0] wr_addr[$];
  logic [15:0] wr_data[$];

  prog_load_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .load_start (load_start),
    .run        (run),
    .step       (step),
    .stop       (stop),
    .cpu_halted (cpu_halted),
    .cpu_reset  (cpu_reset),
    .cpu_ce     (cpu_ce),
    .mem_sel    (mem_sel),
    .ld_mw_en   (ld_mw_en),
    .ld_addr    (ld_addr),
    .ld_wdata   (ld_wdata),
    .state      (state)
  );

  always #5 clk = ~clk;

  // Log every memory write seen mid-cycle.
  always @(negedge clk) begin
    if (ld_mw_en === 1'b1) begin
      wr_addr.push_back(ld_addr);
      wr_data.push_back(ld_wdata);
    end
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic pulse_load();
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
  endtask

  initial begin
    // Reset state
    tick(); tick();
    chk("rst_state", {12'd0, state}, 16'd0);
    chk("rst_cpu_reset", {15'd0, cpu_reset}, 16'd1);
    chk("rst_cpu_ce", {15'd0, cpu_ce}, 16'd0);
    chk("rst_mem_sel", {15'd0, mem_sel}, 16'd1);
    chk("rst_mw_en", {15'd0, ld_mw_en}, 16'd0);
    chk("rst_addr", ld_addr, 16'h0000);
    chk("rst_wdata", ld_wdata, 16'h0000);
    reset = 1'b0;
    tick();

    // Stray byte in IDLE is ignored
    send_byte(8'h77);
    chk("idle_rx_ignored", {12'd0, state}, 16'd0);

    // Two-word download: 00 02 12 34 AB CD
    pulse_load();
    chk("dl_len_hi", {12'd0, state}, 16'd1);
    send_byte(8'h00);
    chk("dl_len_lo", {12'd0, state}, 16'd2);
    send_byte(8'h02);
    chk("dl_dat_hi", {12'd0, state}, 16'd3);
    send_byte(8'h12);
    chk("dl_dat_lo", {12'd0, state}, 16'd4);
    chk("dl_no_write_yet", {15'd0, ld_mw_en}, 16'd0);
    send_byte(8'h34);
    chk("dl_write0_state", {12'd0, state}, 16'd5);
    chk("dl_write0_en", {15'd0, ld_mw_en}, 16'd1);
    chk("dl_write0_addr", ld_addr, 16'h0000);
    chk("dl_write0_data", ld_wdata, 16'h1234);
    tick();
    chk("dl_back_dat_hi", {12'd0, state}, 16'd3);
    chk("dl_addr_inc", ld_addr, 16'h0001);
    chk("dl_en_low", {15'd0, ld_mw_en}, 16'd0);
    send_byte(8'hAB);
    send_byte(8'hCD);
    chk("dl_write1_addr", ld_addr, 16'h0001);
    chk("dl_write1_data", ld_wdata, 16'hABCD);
    tick();
    chk("dl_ready", {12'd0, state}, 16'd6);
    chk("dl_ready_cpu_reset", {15'd0, cpu_reset}, 16'd0);
    chk("dl_ready_mem_sel", {15'd0, mem_sel}, 16'd0);
    chk("dl_ready_ce", {15'd0, cpu_ce}, 16'd0);
    chk("dl_wr_count", 16'(wr_addr.size()), 16'd2);
    chk("dl_wr0_addr", wr_addr[0], 16'h0000);
    chk("dl_wr0_data", wr_data[0], 16'h1234);
    chk("dl_wr1_addr", wr_addr[1], 16'h0001);
    chk("dl_wr1_data", wr_data[1], 16'hABCD);

    // Single step from READY
    step = 1'b1; tick(); step = 1'b0;
    chk("step_state", {12'd0, state}, 16'd8);
    chk("step_ce", {15'd0, cpu_ce}, 16'd1);
    tick();
    chk("step_back_ready", {12'd0, state}, 16'd6);
    chk("step_ce_off", {15'd0, cpu_ce}, 16'd0);

    // Run then stop
    run = 1'b1; tick(); run = 1'b0;
    chk("run_state", {12'd0, state}, 16'd7);
    stop = 1'b1; tick(); stop = 1'b0;
    chk("stop_ready", {12'd0, state}, 16'd6);

    // Zero-length download
    pulse_load();
    send_byte(8'h00);
    send_byte(8'h00);
    chk("zlen_ready", {12'd0, state}, 16'd6);
    chk("zlen_cpu_reset", {15'd0, cpu_reset}, 16'd0);
    chk("zlen_no_writes", 16'(wr_addr.size()), 16'd2);

    // One-word download with run pulse during DAT_LO
    pulse_load();
    send_byte(8'h00);
    send_byte(8'h01);
    send_byte(8'h55);
    run = 1'b1;
    send_byte(8'h66);
    run = 1'b0;
    chk("runign_write", {12'd0, state}, 16'd5);
    chk("runign_data", ld_wdata, 16'h5566);
    tick();
    chk("runign_ready", {12'd0, state}, 16'd6);
    chk("runign_wr_count", 16'(wr_addr.size()), 16'd3);
    chk("runign_wr_addr", wr_addr[2], 16'h0000);

    // run + step together, then halt beats stop
    run = 1'b1; step = 1'b1; tick(); run = 1'b0; step = 1'b0;
    chk("rs_run_state", {12'd0, state}, 16'd7);
    chk("rs_ce", {15'd0, cpu_ce}, 16'd1);
    tick();
    chk("rs_ce_hold", {15'd0, cpu_ce}, 16'd1);
    cpu_halted = 1'b1; stop = 1'b1; tick(); stop = 1'b0;
    chk("halt_state", {12'd0, state}, 16'd9);
    chk("halt_ce", {15'd0, cpu_ce}, 16'd0);
    cpu_halted = 1'b0;
    run = 1'b1; tick(); run = 1'b0;
    chk("halt_run_ignored", {12'd0, state}, 16'd9);

    // Reset mid-download after byte 12
    pulse_load();
    send_byte(8'h00);
    send_byte(8'h02);
    send_byte(8'h12);
    reset = 1'b1;
    #1;
    chk("abort_state", {12'd0, state}, 16'd0);
    chk("abort_addr", ld_addr, 16'h0000);
    chk("abort_wdata", ld_wdata, 16'h0000);
    rx_valid = 1'b1; rx_data = 8'h34;
    tick();
    rx_valid = 1'b0;
    reset = 1'b0;
    tick();
    chk("abort_no_write", 16'(wr_addr.size()), 16'd3);

    // Fresh download after abort
    pulse_load();
    send_byte(8'h00);
    send_byte(8'h02);
    send_byte(8'h12);
    send_byte(8'h34);
    tick();
    send_byte(8'hAB);
    send_byte(8'hCD);
    tick();
    chk("fresh_ready", {12'd0, state}, 16'd6);
    chk("fresh_wr_count", 16'(wr_addr.size()), 16'd5);
    chk("fresh_wr0", wr_data[3], 16'h1234);
    chk("fresh_wr1_addr", wr_addr[4], 16'h0001);
    chk("fresh_wr1", wr_data[4], 16'hABCD);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
